riot_kbd_scan_ctrl: RTL and testbench
=====================================

RIOT_KBD_SCAN_CTRL -- requirements
Module: riot_kbd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles between the starts of successive scan passes (minimum 64).
REQ-002 SHALL have parameter SETTLE, default 4, meaning wait cycles between a column write and its row read (minimum 1).
REQ-003 SHALL have parameter DEBOUNCE, default 3, meaning the number of consecutive identical full passes needed to accept a key (minimum 1).
REQ-004 clk  in  1  single system clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_cs, cpu_rw, cpu_rs  in  1 each  CPU request toward the RIOT.
REQ-007 cpu_addr  in  7; cpu_din  in  8  CPU address and write data.
REQ-008 riot_cs, riot_rw, riot_rs  out  1 each  muxed RIOT controls.
REQ-009 riot_addr  out  7; riot_din  out  8  muxed RIOT address and write data.
REQ-010 riot_dout  in  8  RIOT read data, registered by the RIOT one clock after a read strobe.
REQ-011 key_valid  out  1  accepted key pending.
REQ-012 key_code  out  6  {col[2:0],row[2:0]} of the accepted key.
REQ-013 key_ack  in  1  consumer acknowledge.
REQ-014 key_overrun  out  1  one-cycle pulse when a new key is dropped.

Function
REQ-015 Bus mux SHALL be combinational: cpu_cs=1 drives riot_* from cpu_* unchanged; otherwise from the scanner, with riot_cs=0 when the scanner is not issuing.
REQ-016 The CPU SHALL always have priority; a scanner bus cycle attempted while cpu_cs=1 SHALL stall, holding FSM state, counters and data, and retry on the next cycle.
REQ-017 FSM states SHALL be INIT_A, INIT_B, WAIT_TICK, DRIVE, SETTLE_W, READ, CAPTURE, EVAL.
REQ-018 INIT_A SHALL write 0xFF to rs=1 addr 1 (DDRA), then go to INIT_B.
REQ-019 INIT_B SHALL write 0x00 to rs=1 addr 3 (DDRB), then go to WAIT_TICK.
REQ-020 A free-running divider SHALL count 0..SCAN_DIV-1 and wrap; WAIT_TICK SHALL leave at count 0 with col=0 and hit register cleared.
REQ-021 DRIVE SHALL write ~(8'h01<<col) to rs=1 addr 0, then spend SETTLE cycles in SETTLE_W.
REQ-022 READ SHALL issue a read of rs=1 addr 2.
REQ-023 CAPTURE (the next cycle) SHALL sample riot_dout; the CAPTURE cycle itself needs no bus grant.
REQ-024 Row r is pressed when bit r of the captured byte is 0.
REQ-025 First hit in scan order (col ascending, row ascending) SHALL be recorded for the pass.
REQ-026 col SHALL increment; after col=7 the FSM goes to EVAL, otherwise to DRIVE.
REQ-027 EVAL, hit present and code equal to the previous pass: stable count increments, saturating at DEBOUNCE.
REQ-028 EVAL, hit present and code different: stable count SHALL be set to 1.
REQ-029 EVAL, no hit: stable count cleared and release flag set.
REQ-030 Acceptance SHALL occur when the count reaches DEBOUNCE with release flag set: load key_code, set key_valid, clear release flag; each press is reported once.
REQ-031 If acceptance occurs while key_valid=1, the key SHALL be dropped, key_overrun pulsed for one cycle, and key_code kept unchanged.
REQ-032 key_ack=1 SHALL clear key_valid next cycle; key_ack with key_valid=0 is ignored.
REQ-033 Simultaneous ack and acceptance SHALL result in the new key loaded with key_valid=1, no overrun.
REQ-034 A CPU write (cpu_cs=1, cpu_rs=1, cpu_rw=0, cpu_addr<=3) during DRIVE..CAPTURE SHALL mark the pass corrupt; EVAL of a corrupt pass leaves count, release flag and outputs unchanged.
REQ-035 The mux SHALL add zero cycles of latency to CPU accesses.

Reset
REQ-036 On reset=1 at a clk edge: state=INIT_A, col=0, divider=0, stable count=0, release flag=1, corrupt=0, key_valid=0, key_code=0, key_overrun=0; scanner bus idle.
REQ-037 Reset mid-pass SHALL abort the pass with no key reported, and re-run INIT_A/INIT_B.

Verification
REQ-038 Post-reset, cpu_cs=0 -> cycle 1 writes FF to addr1, cycle 2 writes 00 to addr3, all outputs 0.
REQ-039 Key col3,row5 held for 3 passes (DEBOUNCE=3) -> key_valid=1, key_code=0x1D after the third EVAL; ack clears; still held -> no second report.
REQ-040 cpu_cs=1 for 10 cycles during READ -> riot_* mirrors CPU, scanner stalls 10 cycles, captured row correct.
REQ-041 Keys 0x1D and 0x0A both held -> 0x0A reported.
REQ-042 key_valid unacked, release, then press 0x22 for 3 passes -> key_overrun pulses once, key_code stays 0x1D.
REQ-043 CPU writes addr0 mid-pass -> that pass discarded, debounce count unchanged.

Source files
------------

// File: rtl/riot_kbd_scan_ctrl.sv
// Keyboard matrix scanner sharing a RIOT with the CPU, with debounce and one-deep key buffer.
// Zero-cycle combinational bus mux; CPU cs always wins and stalls any pending scanner bus cycle.
module riot_kbd_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_cs,
    input  logic       cpu_rw,
    input  logic       cpu_rs,
    input  logic [6:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       riot_cs,
    output logic       riot_rw,
    output logic       riot_rs,
    output logic [6:0] riot_addr,
    output logic [7:0] riot_din,
    input  logic [7:0] riot_dout,
    output logic       key_valid,
    output logic [5:0] key_code,
    input  logic       key_ack,
    output logic       key_overrun
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        INIT_A, INIT_B, WAIT_TICK, DRIVE, SETTLE_W, READ, CAPTURE, EVAL
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       col;
    logic [SET_W-1:0] settle_cnt;
    logic             hit_vld;
    logic [5:0]       hit_code;
    logic [5:0]       prev_code;
    logic [CNT_W-1:0] stable_cnt;
    logic             released;
    logic             corrupt;

    logic             scan_cs, scan_rw;
    logic [6:0]       scan_addr;
    logic [7:0]       scan_din;
    logic             grant;
    logic             row_any;
    logic [2:0]       row_idx;
    logic [CNT_W-1:0] cnt_inc, eval_cnt;
    logic             accept;
    logic             in_pass, cpu_port_wr;

    assign grant     = !cpu_cs;
    assign riot_cs   = cpu_cs ? 1'b1     : scan_cs;
    assign riot_rw   = cpu_cs ? cpu_rw   : scan_rw;
    assign riot_rs   = cpu_cs ? cpu_rs   : 1'b1;
    assign riot_addr = cpu_cs ? cpu_addr : scan_addr;
    assign riot_din  = cpu_cs ? cpu_din  : scan_din;

    always_comb begin
        scan_cs   = 1'b0;
        scan_rw   = 1'b1;
        scan_addr = 7'd0;
        scan_din  = 8'h00;
        case (state)
            INIT_A:  begin scan_cs = 1'b1; scan_rw = 1'b0; scan_addr = 7'd1; scan_din = 8'hFF; end
            INIT_B:  begin scan_cs = 1'b1; scan_rw = 1'b0; scan_addr = 7'd3; scan_din = 8'h00; end
            DRIVE:   begin scan_cs = 1'b1; scan_rw = 1'b0; scan_addr = 7'd0; scan_din = ~(8'h01 << col); end
            READ:    begin scan_cs = 1'b1; scan_rw = 1'b1; scan_addr = 7'd2; end
            default: ;
        endcase
        if (reset) scan_cs = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT_A:    if (grant) state_nxt = INIT_B;
            INIT_B:    if (grant) state_nxt = WAIT_TICK;
            WAIT_TICK: if (div_cnt == '0) state_nxt = DRIVE;
            DRIVE:     if (grant) state_nxt = SETTLE_W;
            SETTLE_W:  if (settle_cnt == SET_W'(SETTLE - 1)) state_nxt = READ;
            READ:      if (grant) state_nxt = CAPTURE;
            CAPTURE:   state_nxt = (col == 3'd7) ? EVAL : DRIVE;
            EVAL:      state_nxt = WAIT_TICK;
            default:   state_nxt = INIT_A;
        endcase
    end

    // Lowest active-low row bit wins, giving row-ascending priority within a column.
    always_comb begin
        row_any = 1'b0;
        row_idx = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            if (!riot_dout[r]) begin
                row_any = 1'b1;
                row_idx = 3'(r);
            end
        end
    end

    always_comb begin
        cnt_inc  = (stable_cnt == CNT_W'(DEBOUNCE)) ? stable_cnt : stable_cnt + CNT_W'(1);
        eval_cnt = (hit_code == prev_code) ? cnt_inc : CNT_W'(1);
    end

    assign accept      = hit_vld && released && (eval_cnt == CNT_W'(DEBOUNCE));
    assign in_pass     = (state == DRIVE) || (state == SETTLE_W) || (state == READ) || (state == CAPTURE);
    assign cpu_port_wr = cpu_cs && cpu_rs && !cpu_rw && (cpu_addr <= 7'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT_A;
            div_cnt     <= '0;
            col         <= 3'd0;
            settle_cnt  <= '0;
            hit_vld     <= 1'b0;
            hit_code    <= 6'd0;
            prev_code   <= 6'd0;
            stable_cnt  <= '0;
            released    <= 1'b1;
            corrupt     <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= 6'd0;
            key_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_overrun <= 1'b0;
            div_cnt     <= (div_cnt == DIV_W'(SCAN_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            if (in_pass && cpu_port_wr) corrupt <= 1'b1;
            if (key_ack) key_valid <= 1'b0;
            case (state)
                WAIT_TICK: if (div_cnt == '0) begin
                    col     <= 3'd0;
                    hit_vld <= 1'b0;
                    corrupt <= 1'b0;
                end
                DRIVE:    if (grant) settle_cnt <= '0;
                SETTLE_W: settle_cnt <= settle_cnt + SET_W'(1);
                CAPTURE: begin
                    if (!hit_vld && row_any) begin
                        hit_vld  <= 1'b1;
                        hit_code <= {col, row_idx};
                    end
                    col <= col + 3'd1;
                end
                // A pass disturbed by a CPU port write is discarded without touching debounce state.
                EVAL: if (!corrupt) begin
                    if (hit_vld) begin
                        stable_cnt <= eval_cnt;
                        prev_code  <= hit_code;
                        if (accept) begin
                            released <= 1'b0;
                            if (key_valid && !key_ack) begin
                                key_overrun <= 1'b1;
                            end else begin
                                key_valid <= 1'b1;
                                key_code  <= hit_code;
                            end
                        end
                    end else begin
                        stable_cnt <= '0;
                        released   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riot_kbd_scan_ctrl.sv
// Bench for riot_kbd_scan_ctrl: RIOT + key-matrix model, pass table, then randomized passes vs a reference model.
module tb_riot_kbd_scan_ctrl;
    localparam int DEB = 3;

    logic       clk, reset;
    logic       cpu_cs, cpu_rw, cpu_rs;
    logic [6:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       riot_cs, riot_rw, riot_rs;
    logic [6:0] riot_addr;
    logic [7:0] riot_din;
    logic [7:0] riot_dout;
    logic       key_valid, key_ack, key_overrun;
    logic [5:0] key_code;

    riot_kbd_scan_ctrl #(.SCAN_DIV(64), .SETTLE(4), .DEBOUNCE(DEB)) dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .riot_cs(riot_cs), .riot_rw(riot_rw), .riot_rs(riot_rs), .riot_addr(riot_addr), .riot_din(riot_din),
        .riot_dout(riot_dout),
        .key_valid(key_valid), .key_code(key_code), .key_ack(key_ack), .key_overrun(key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: bit {col,row} set means that key is pressed.
    logic [63:0] keys;
    logic [7:0]  porta;
    int          ov_cnt;
    int          passed, total;

    function automatic logic [7:0] rows_of(input logic [7:0] pa, input logic [63:0] k);
        logic [7:0] pr;
        pr = 8'h00;
        for (int c = 0; c < 8; c++) if (!pa[c]) pr = pr | k[c*8 +: 8];
        return ~pr;
    endfunction

    initial begin
        porta     = 8'hFF;
        riot_dout = 8'hFF;
        ov_cnt    = 0;
    end

    always @(posedge clk) begin
        if (riot_cs) begin
            if (!riot_rw) begin
                if (riot_rs && riot_addr == 7'd0) porta <= riot_din;
            end else begin
                riot_dout <= (riot_rs && riot_addr == 7'd2) ? rows_of(porta, keys) : 8'h00;
            end
        end
        if (key_overrun) ov_cnt <= ov_cnt + 1;
    end

    typedef struct packed {
        logic [63:0] keys;
        logic        ack;
        logic [1:0]  mode;   // 0 plain, 1 CPU read stall, 2 CPU port write, 3 reset mid-pass
        logic        exp_v;
        logic [5:0]  exp_code;
        logic        exp_ov;
    } rec_t;

    localparam logic [6:0] NK  = 7'h00;
    localparam logic [6:0] K1D = {1'b1, 6'h1D};
    localparam logic [6:0] K0A = {1'b1, 6'h0A};
    localparam logic [6:0] K22 = {1'b1, 6'h22};
    localparam logic [6:0] K05 = {1'b1, 6'h05};
    localparam logic [6:0] K3F = {1'b1, 6'h3F};

    function automatic rec_t mk(input logic [6:0] a, input logic [6:0] b, input logic ack,
                                input logic [1:0] mode, input logic ev, input logic [5:0] ec, input logic eo);
        rec_t t;
        t.keys = '0;
        if (a[6]) t.keys[a[5:0]] = 1'b1;
        if (b[6]) t.keys[b[5:0]] = 1'b1;
        t.ack = ack; t.mode = mode; t.exp_v = ev; t.exp_code = ec; t.exp_ov = eo;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic scan_match(input logic rd, input logic [7:0] pa);
        if (cpu_cs || !riot_cs || !riot_rs) return 1'b0;
        if (rd) return riot_rw && riot_addr == 7'd2 && porta == pa;
        return !riot_rw && riot_addr == 7'd0 && riot_din == pa;
    endfunction

    task automatic wait_scan(input logic rd, input logic [7:0] pa, input string nm);
        int n;
        n = 0;
        while (!scan_match(rd, pa) && n < 400) begin
            tick;
            n++;
        end
        chk($sformatf("%s seen", nm), 64'(scan_match(rd, pa)), 64'd1);
    endtask

    task automatic run_pass(input rec_t v, input int idx);
        int   ov0;
        logic ok;
        keys = v.keys;
        ov0  = ov_cnt;
        wait_scan(1'b0, 8'hFE, $sformatf("p%0d start", idx));
        if (v.mode == 2'd3) begin
            repeat (20) tick;
            reset = 1'b1;
            tick;
            reset = 1'b0;
            #1;
            chk($sformatf("p%0d rst initA", idx), {riot_cs, riot_rw, riot_rs, riot_addr, riot_din},
                {1'b1, 1'b0, 1'b1, 7'd1, 8'hFF});
            chk($sformatf("p%0d rst outs", idx), {key_valid, key_code}, 7'd0);
            wait_scan(1'b0, 8'hFE, $sformatf("p%0d restart", idx));
        end
        if (v.mode == 2'd1 || v.mode == 2'd2) begin
            wait_scan(1'b1, 8'hF7, $sformatf("p%0d col3 read", idx));
            if (v.mode == 2'd1) begin
                cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_rs = 1'b0; cpu_addr = 7'h55; cpu_din = 8'h12;
                ok = 1'b1;
                repeat (10) begin
                    #1;
                    if (!(riot_cs && riot_rw && !riot_rs && riot_addr == 7'h55 && riot_din == 8'h12)) ok = 1'b0;
                    tick;
                end
                cpu_cs = 1'b0;
                #1;
                chk($sformatf("p%0d cpu mirror", idx), 64'(ok), 64'd1);
                chk($sformatf("p%0d read held", idx), {riot_cs, riot_rw, riot_rs, riot_addr}, {1'b1, 1'b1, 1'b1, 7'd2});
            end else begin
                cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_rs = 1'b1; cpu_addr = 7'd0; cpu_din = 8'hFF;
                tick;
                cpu_cs = 1'b0; cpu_rw = 1'b1;
            end
        end
        wait_scan(1'b1, 8'h7F, $sformatf("p%0d col7 read", idx));
        tick;                 // CAPTURE
        tick;                 // EVAL
        key_ack = v.ack;
        tick;
        key_ack = 1'b0;
        chk($sformatf("p%0d key_valid", idx), 64'(key_valid), 64'(v.exp_v));
        chk($sformatf("p%0d key_code", idx), 64'(key_code), 64'(v.exp_code));
        tick;
        chk($sformatf("p%0d overruns", idx), 64'(ov_cnt - ov0), 64'(v.exp_ov));
    endtask

    rec_t        tbl[30];
    logic [5:0]  pool[5];
    int          m_cnt;
    logic [5:0]  m_prev, m_code, hc;
    logic        m_rel, m_valid, m_ov, hit, r_ack;
    logic [63:0] r_keys;
    rec_t        rv;

    initial begin
        //           keys      ack  mode  valid code   ovr
        tbl[0]  = mk(K1D, NK,  0, 0, 0, 6'h00, 0);
        tbl[1]  = mk(K1D, NK,  0, 0, 0, 6'h00, 0);
        tbl[2]  = mk(K1D, NK,  0, 0, 1, 6'h1D, 0);
        tbl[3]  = mk(K1D, NK,  0, 0, 1, 6'h1D, 0);
        tbl[4]  = mk(NK,  NK,  0, 0, 1, 6'h1D, 0);
        tbl[5]  = mk(K22, NK,  0, 0, 1, 6'h1D, 0);
        tbl[6]  = mk(K22, NK,  0, 0, 1, 6'h1D, 0);
        tbl[7]  = mk(K22, NK,  0, 0, 1, 6'h1D, 1);
        tbl[8]  = mk(NK,  NK,  1, 0, 0, 6'h1D, 0);
        tbl[9]  = mk(K0A, K1D, 0, 0, 0, 6'h1D, 0);
        tbl[10] = mk(K0A, K1D, 0, 0, 0, 6'h1D, 0);
        tbl[11] = mk(K0A, K1D, 0, 0, 1, 6'h0A, 0);
        tbl[12] = mk(K0A, K1D, 1, 0, 0, 6'h0A, 0);
        tbl[13] = mk(K1D, NK,  0, 0, 0, 6'h0A, 0);
        tbl[14] = mk(NK,  NK,  0, 0, 0, 6'h0A, 0);
        tbl[15] = mk(K05, NK,  0, 0, 0, 6'h0A, 0);
        tbl[16] = mk(K05, NK,  0, 0, 0, 6'h0A, 0);
        tbl[17] = mk(K05, NK,  0, 0, 1, 6'h05, 0);
        tbl[18] = mk(NK,  NK,  0, 0, 1, 6'h05, 0);
        tbl[19] = mk(K3F, NK,  0, 0, 1, 6'h05, 0);
        tbl[20] = mk(K3F, NK,  0, 0, 1, 6'h05, 0);
        tbl[21] = mk(K3F, NK,  1, 0, 1, 6'h3F, 0);
        tbl[22] = mk(NK,  NK,  1, 0, 0, 6'h3F, 0);
        tbl[23] = mk(K1D, NK,  0, 1, 0, 6'h3F, 0);
        tbl[24] = mk(K1D, NK,  0, 0, 0, 6'h3F, 0);
        tbl[25] = mk(K1D, NK,  0, 2, 0, 6'h3F, 0);
        tbl[26] = mk(K1D, NK,  0, 0, 1, 6'h1D, 0);
        tbl[27] = mk(K1D, NK,  0, 3, 0, 6'h00, 0);
        tbl[28] = mk(K1D, NK,  0, 0, 0, 6'h00, 0);
        tbl[29] = mk(K1D, NK,  0, 0, 1, 6'h1D, 0);
        pool[0] = 6'h00; pool[1] = 6'h3F; pool[2] = 6'h1D; pool[3] = 6'h1C; pool[4] = 6'h2A;

        passed = 0; total = 0;
        keys = '0;
        reset = 1'b1; key_ack = 1'b0;
        cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_rs = 1'b0; cpu_addr = 7'd0; cpu_din = 8'h00;
        repeat (3) tick;
        chk("reset bus idle", 64'(riot_cs), 64'd0);
        chk("reset outputs", {key_valid, key_code, key_overrun}, 8'd0);
        reset = 1'b0;
        #1;
        chk("init DDRA write", {riot_cs, riot_rw, riot_rs, riot_addr, riot_din}, {1'b1, 1'b0, 1'b1, 7'd1, 8'hFF});
        tick;
        chk("init DDRB write", {riot_cs, riot_rw, riot_rs, riot_addr, riot_din}, {1'b1, 1'b0, 1'b1, 7'd3, 8'h00});
        tick;
        chk("wait tick idle", {riot_cs, key_valid, key_code, key_overrun}, 9'd0);

        for (int i = 0; i < 30; i++) run_pass(tbl[i], i);

        // Randomized passes against a reference model; first hit in scan order is the smallest code.
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        m_cnt = 0; m_prev = 6'd0; m_rel = 1'b1; m_valid = 1'b0; m_code = 6'd0;
        r_keys = '0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || $urandom_range(1, 0) == 0) begin
                r_keys = '0;
                for (int j = 0; j < 5; j++) if ($urandom_range(4, 0) == 0) r_keys[pool[j]] = 1'b1;
            end
            r_ack = ($urandom_range(3, 0) == 0);
            hit = 1'b0; hc = 6'd0; m_ov = 1'b0;
            for (int c = 0; c < 64; c++) if (r_keys[c] && !hit) begin hit = 1'b1; hc = 6'(c); end
            if (hit) begin
                m_cnt  = (hc == m_prev) ? ((m_cnt < DEB) ? m_cnt + 1 : DEB) : 1;
                m_prev = hc;
            end else begin
                m_cnt = 0;
                m_rel = 1'b1;
            end
            if (hit && m_cnt == DEB && m_rel) begin
                m_rel = 1'b0;
                if (m_valid && !r_ack) m_ov = 1'b1;
                else begin m_valid = 1'b1; m_code = hc; end
            end else if (r_ack) begin
                m_valid = 1'b0;
            end
            rv.keys = r_keys; rv.ack = r_ack; rv.mode = 2'd0;
            rv.exp_v = m_valid; rv.exp_code = m_code; rv.exp_ov = m_ov;
            run_pass(rv, 100 + i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
